// File: rtl/arq_tx_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | arq_tx_ctrl_pkg: state encoding, parameter defaults and counter sizing.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package arq_tx_ctrl_pkg;

  localparam logic [2:0] C_ST_IDLE       = 3'd0;
  localparam logic [2:0] C_ST_SEND       = 3'd1;
  localparam logic [2:0] C_ST_WAIT_ACK   = 3'd2;
  localparam logic [2:0] C_ST_REPLAY_REQ = 3'd3;
  localparam logic [2:0] C_ST_REPLAY     = 3'd4;
  localparam logic [2:0] C_ST_DONE       = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE       = C_ST_IDLE,
    ST_SEND       = C_ST_SEND,
    ST_WAIT_ACK   = C_ST_WAIT_ACK,
    ST_REPLAY_REQ = C_ST_REPLAY_REQ,
    ST_REPLAY     = C_ST_REPLAY,
    ST_DONE       = C_ST_DONE
  } state_t;

  localparam int C_FRAME_BYTES_DEF = 64;
  localparam int C_ACK_TIMEOUT_DEF = 100000;
  localparam int C_MAX_RETRIES_DEF = 3;

  // Bits needed for n distinct values, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arq_ack_timer.sv
// +----------------------------------------------------------------------------+
// | arq_ack_timer: counts cycles while run is high, pulses expired on the      |
// | ACK_TIMEOUT-th counted cycle.                                  Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module arq_ack_timer
  import arq_tx_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = C_ACK_TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int TW = cnt_width(ACK_TIMEOUT);

  logic [TW-1:0] r_count;

  assign o_expired = i_run && (r_count == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= o_expired ? '0 : r_count + TW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/arq_tx_ctrl.sv
// +----------------------------------------------------------------------------+
// | arq_tx_ctrl: ARQ transmit sequencer (send, await ACK, replay, retire).     |
// | Optional ARQ_TX_CTRL_STATS_EN adds replay/drop counters.       Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module arq_tx_ctrl
  import arq_tx_ctrl_pkg::*;
#(
  parameter int FRAME_BYTES = C_FRAME_BYTES_DEF,
  parameter int ACK_TIMEOUT = C_ACK_TIMEOUT_DEF,
  parameter int MAX_RETRIES = C_MAX_RETRIES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_arq_en,
  input  logic i_byte_xfer,
  input  logic i_frame_fas,
  input  logic i_ack_valid,
  input  logic i_ack_ok,
  output logic o_read_line_fifo,
  output logic o_retrans_req,
  output logic o_send_complete,
  output logic o_frame_drop,
  output logic o_busy
`ifdef ARQ_TX_CTRL_STATS_EN
  ,
  output logic [15:0] o_retrans_cnt,
  output logic [15:0] o_drop_cnt
`endif
);

  localparam int BW = cnt_width(FRAME_BYTES + 1);
  localparam int RW = cnt_width(MAX_RETRIES + 1);

  state_t        r_state;
  logic [BW-1:0] r_byte_cnt;
  logic [RW-1:0] r_retry_cnt;
  logic          r_arq_en_q;
  logic          w_in_wait;
  logic          w_expired;
  logic          w_last_byte;

  assign w_in_wait   = (r_state == ST_WAIT_ACK);
  assign w_last_byte = i_byte_xfer && (r_byte_cnt == BW'(FRAME_BYTES - 1));

  arq_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (!w_in_wait),
    .i_run     (w_in_wait),
    .o_expired (w_expired)
  );

  // Outputs are assigned alongside the transition into the state they belong to.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= ST_IDLE;
      r_byte_cnt       <= '0;
      r_retry_cnt      <= '0;
      r_arq_en_q       <= 1'b0;
      o_read_line_fifo <= 1'b0;
      o_retrans_req    <= 1'b0;
      o_send_complete  <= 1'b0;
      o_frame_drop     <= 1'b0;
      o_busy           <= 1'b0;
    end else begin
      o_retrans_req   <= 1'b0;
      o_send_complete <= 1'b0;
      o_frame_drop    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_byte_xfer && i_frame_fas) begin
            r_state    <= ST_SEND;
            r_byte_cnt <= BW'(1);
            r_arq_en_q <= i_arq_en;
            o_busy     <= 1'b1;
          end
        end
        ST_SEND: begin
          if (i_byte_xfer) begin
            r_byte_cnt <= r_byte_cnt + BW'(1);
          end
          if (w_last_byte) begin
            if (r_arq_en_q) begin
              r_state <= ST_WAIT_ACK;
            end else begin
              r_state         <= ST_DONE;
              o_send_complete <= 1'b1;
            end
          end
        end
        ST_WAIT_ACK: begin
          // A good ACK takes priority over a coincident timeout.
          if (i_ack_valid && i_ack_ok) begin
            r_state         <= ST_DONE;
            o_send_complete <= 1'b1;
          end else if (i_ack_valid || w_expired) begin
            if (r_retry_cnt == RW'(MAX_RETRIES)) begin
              r_state         <= ST_DONE;
              o_send_complete <= 1'b1;
              o_frame_drop    <= 1'b1;
            end else begin
              r_state          <= ST_REPLAY_REQ;
              o_retrans_req    <= 1'b1;
              o_read_line_fifo <= 1'b1;
            end
          end
        end
        ST_REPLAY_REQ: begin
          r_state     <= ST_REPLAY;
          r_retry_cnt <= r_retry_cnt + RW'(1);
          r_byte_cnt  <= '0;
        end
        ST_REPLAY: begin
          if (i_byte_xfer) begin
            r_byte_cnt <= r_byte_cnt + BW'(1);
          end
          if (w_last_byte) begin
            r_state          <= ST_WAIT_ACK;
            o_read_line_fifo <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_retry_cnt <= '0;
          o_busy      <= 1'b0;
        end
        default: begin
          r_state          <= ST_IDLE;
          r_retry_cnt      <= '0;
          o_read_line_fifo <= 1'b0;
          o_busy           <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARQ_TX_CTRL_STATS_EN
  // Counts follow the registered pulses, so they lag the event by one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_retrans_cnt <= '0;
      o_drop_cnt    <= '0;
    end else begin
      if (o_retrans_req && (o_retrans_cnt != 16'hFFFF)) begin
        o_retrans_cnt <= o_retrans_cnt + 16'd1;
      end
      if (o_frame_drop && (o_drop_cnt != 16'hFFFF)) begin
        o_drop_cnt <= o_drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_arq_tx_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_arq_tx_ctrl: directed and random stimulus against a frame-level model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_arq_tx_ctrl;

  localparam int FB = 8;
  localparam int AT = 20;
  localparam int MR = 2;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic i_arq_en = 1'b0;
  logic i_byte_xfer = 1'b0;
  logic i_frame_fas = 1'b0;
  logic i_ack_valid = 1'b0;
  logic i_ack_ok = 1'b0;
  logic o_read_line_fifo;
  logic o_retrans_req;
  logic o_send_complete;
  logic o_frame_drop;
  logic o_busy;
`ifdef ARQ_TX_CTRL_STATS_EN
  logic [15:0] o_retrans_cnt;
  logic [15:0] o_drop_cnt;
`endif

  always #5 i_clk = ~i_clk;

  arq_tx_ctrl #(
    .FRAME_BYTES (FB),
    .ACK_TIMEOUT (AT),
    .MAX_RETRIES (MR)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_arq_en         (i_arq_en),
    .i_byte_xfer      (i_byte_xfer),
    .i_frame_fas      (i_frame_fas),
    .i_ack_valid      (i_ack_valid),
    .i_ack_ok         (i_ack_ok),
    .o_read_line_fifo (o_read_line_fifo),
    .o_retrans_req    (o_retrans_req),
    .o_send_complete  (o_send_complete),
    .o_frame_drop     (o_frame_drop),
    .o_busy           (o_busy)
`ifdef ARQ_TX_CTRL_STATS_EN
    ,
    .o_retrans_cnt    (o_retrans_cnt),
    .o_drop_cnt       (o_drop_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame-level reference: where the current frame is and what it owes downstream.
  bit m_sending, m_replaying, m_waiting, m_req_now, m_done_now, m_drop_now, m_arq;
  int m_bytes, m_waited, m_replays, m_retrans_total, m_drop_total;

  int obs_req, obs_done, obs_drop, obs_read;

  task automatic model_reset();
    m_sending = 0; m_replaying = 0; m_waiting = 0; m_req_now = 0;
    m_done_now = 0; m_drop_now = 0; m_arq = 0;
    m_bytes = 0; m_waited = 0; m_replays = 0;
    m_retrans_total = 0; m_drop_total = 0;
  endtask

  task automatic model_retire(input bit dropped);
    m_sending = 0; m_replaying = 0; m_waiting = 0;
    m_done_now = 1; m_drop_now = dropped;
  endtask

  task automatic model_step(input bit xf, input bit fas, input bit av, input bit ok, input bit en);
    if (m_done_now) begin
      if (m_drop_now) m_drop_total++;
      m_done_now = 0; m_drop_now = 0; m_replays = 0;
    end else if (m_req_now) begin
      m_req_now = 0; m_replaying = 1; m_bytes = 0;
      m_replays++; m_retrans_total++;
    end else if (m_waiting) begin
      if (av && ok) model_retire(0);
      else if (av || m_waited == AT - 1) begin
        if (m_replays == MR) model_retire(1);
        else begin m_waiting = 0; m_req_now = 1; end
      end else m_waited++;
    end else if (m_sending || m_replaying) begin
      if (xf) begin
        m_bytes++;
        if (m_bytes == FB) begin
          if (m_replaying || m_arq) begin
            m_sending = 0; m_replaying = 0; m_waiting = 1; m_waited = 0;
          end else model_retire(0);
        end
      end
    end else if (xf && fas) begin
      m_sending = 1; m_bytes = 1; m_arq = en;
    end
  endtask

  task automatic check_outputs();
    bit busy;
    busy = m_sending || m_replaying || m_waiting || m_req_now || m_done_now;
    chk("read_line_fifo", o_read_line_fifo, 32'(m_req_now || m_replaying));
    chk("retrans_req", o_retrans_req, 32'(m_req_now));
    chk("send_complete", o_send_complete, 32'(m_done_now));
    chk("frame_drop", o_frame_drop, 32'(m_drop_now));
    chk("busy", o_busy, 32'(busy));
`ifdef ARQ_TX_CTRL_STATS_EN
    chk("retrans_cnt", o_retrans_cnt, 32'(m_retrans_total));
    chk("drop_cnt", o_drop_cnt, 32'(m_drop_total));
`endif
    if (o_retrans_req === 1'b1) obs_req++;
    if (o_send_complete === 1'b1) obs_done++;
    if (o_frame_drop === 1'b1) obs_drop++;
    if (o_read_line_fifo === 1'b1) obs_read++;
  endtask

  task automatic clear_obs();
    obs_req = 0; obs_done = 0; obs_drop = 0; obs_read = 0;
  endtask

  // Called at a negedge; applies one cycle of inputs and checks after the next posedge.
  task automatic step(input bit xf, input bit fas, input bit av, input bit ok, input bit en);
    i_byte_xfer = xf; i_frame_fas = fas; i_ack_valid = av; i_ack_ok = ok; i_arq_en = en;
    model_step(xf, fas, av, ok, en);
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  // FAS plus the remaining FB-1 bytes back to back.
  task automatic send_frame(input bit en);
    step(1, 1, 0, 0, en);
    for (int k = 1; k < FB; k++) step(1, 0, 0, 0, en);
  endtask

  // Asynchronous: outputs must clear before any clock edge.
  task automatic do_reset();
    i_byte_xfer = 0; i_frame_fas = 0; i_ack_valid = 0; i_ack_ok = 0;
    i_rst = 1'b1;
    #1;
    chk("rst_read", o_read_line_fifo, 0);
    chk("rst_req", o_retrans_req, 0);
    chk("rst_done", o_send_complete, 0);
    chk("rst_drop", o_frame_drop, 0);
    chk("rst_busy", o_busy, 0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    @(negedge i_clk);
    do_reset();

    // ARQ off: completes one cycle after the last byte, never touches the line FIFO.
    clear_obs();
    send_frame(0);
    chk("t1_complete_now", o_send_complete, 1);
    idle(3);
    chk("t1_done", obs_done, 1);
    chk("t1_read", obs_read, 0);

    // ARQ on, ACK five cycles after the last byte.
    do_reset(); clear_obs();
    send_frame(1);
    idle(4);
    step(0, 0, 1, 1, 0);
    chk("t2_complete_now", o_send_complete, 1);
    idle(3);
    chk("t2_done", obs_done, 1);
    chk("t2_drop", obs_drop, 0);
    chk("t2_req", obs_req, 0);

    // NACK, one replay of FB bytes, then ACK.
    do_reset(); clear_obs();
    send_frame(1);
    idle(3);
    step(0, 0, 1, 0, 0);
    chk("t3_req_now", o_retrans_req, 1);
    idle(1);
    for (int k = 0; k < FB; k++) step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    idle(2);
    chk("t3_req", obs_req, 1);
    chk("t3_read_cycles", obs_read, 1 + FB);
    chk("t3_done", obs_done, 1);
    chk("t3_read_end", o_read_line_fifo, 0);

    // No ACK at all: two replays then a drop.
    do_reset(); clear_obs();
    send_frame(1);
    for (int k = 0; k < 100; k++) step(1, 0, 0, 0, 0);
    chk("t4_req", obs_req, MR);
    chk("t4_drop", obs_drop, 1);
    chk("t4_done", obs_done, 1);
`ifdef ARQ_TX_CTRL_STATS_EN
    chk("t4_stat_retrans", o_retrans_cnt, MR);
    chk("t4_stat_drop", o_drop_cnt, 1);
`endif

    // Strobes during SEND are ignored; ACK coincident with expiry wins.
    do_reset(); clear_obs();
    step(1, 1, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 1, 1);
    for (int k = 3; k < FB; k++) step(1, 0, 0, 0, 1);
    chk("t5_still_busy", o_busy, 1);
    chk("t5_no_early_done", obs_done, 0);
    idle(AT - 1);
    step(0, 0, 1, 1, 0);
    idle(3);
    chk("t5_req", obs_req, 0);
    chk("t5_drop", obs_drop, 0);
    chk("t5_done", obs_done, 1);

    // Reset in the middle of a replay, then a full-retry frame from scratch.
    do_reset(); clear_obs();
    send_frame(1);
    step(0, 0, 1, 0, 0);
    idle(1);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0);
    chk("t6_replaying", o_read_line_fifo, 1);
    do_reset(); clear_obs();
    send_frame(1);
    for (int k = 0; k < 100; k++) step(1, 0, 0, 0, 0);
    chk("t6_req_after_rst", obs_req, MR);
    chk("t6_drop_after_rst", obs_drop, 1);

    // Random traffic, with occasional asynchronous resets.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 30),
                ($urandom_range(0, 99) < 8), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
